// File: rtl/cla_pipe_addsub_pkg.sv
// Shared types and elaboration helpers for the pipelined CLA add/sub unit.
// Segment and group sizing are derived here so every file agrees on them.
package cla_pipe_addsub_pkg;

    typedef struct packed {
        logic c;
        logic ovf;
        logic zero;
    } flags_t;

    function automatic bit cfg_ok(input int w, input int blk, input int stg);
        return (w > 0) && (blk > 0) && (stg > 0) && (w % (blk * stg) == 0);
    endfunction

    function automatic int seg_w(input int w, input int stg);
        return w / stg;
    endfunction

    function automatic int grp_per_seg(input int w, input int blk, input int stg);
        return w / (blk * stg);
    endfunction

endpackage

// File: rtl/cla_pipe_addsub_block.sv
// One BLOCK-bit carry-look-ahead group with group generate/propagate.
// G/P are kept independent of cin so the group-level look-ahead stays acyclic.
module cla_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             g,
    output logic             p,
    output logic             cout
);

    logic [BLOCK-1:0] bit_g;
    logic [BLOCK-1:0] bit_p;
    logic [BLOCK-1:0] c;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    always_comb begin
        g = 1'b0;
        p = 1'b1;
        for (int i = BLOCK - 1; i >= 0; i--) begin
            g = g | (p & bit_g[i]);
            p = p & bit_p[i];
        end
    end

    // Every bit carry is a flat sum-of-products of cin and the lower g/p.
    always_comb begin : carries
        logic ga;
        logic pa;
        c  = '0;
        ga = 1'b0;
        pa = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            ga = 1'b0;
            pa = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                ga = ga | (pa & bit_g[j]);
                pa = pa & bit_p[j];
            end
            c[i] = ga | (pa & cin);
        end
    end

    assign sum  = bit_p ^ c;
    assign cout = g | (p & cin);

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: one WIDTH/STAGES segment per stage,
// carry and skewed operands registered between stages, valid/ready flow.
module cla_pipe_addsub
    import cla_pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int SEG = seg_w(WIDTH, STAGES);
    localparam int GPS = grp_per_seg(WIDTH, BLOCK, STAGES);

    if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_cfg
        $error("cla_pipe_addsub: WIDTH must be a multiple of BLOCK*STAGES");
    end

    logic [STAGES:1] v_q;
    logic [STAGES:1] v_in;
    logic [STAGES:1] ld;

    // A stage loads when empty or when its occupant moves on, so bubbles
    // are squeezed out even while the output is stalled.
    always_comb begin
        ld         = '0;
        v_in       = '0;
        ld[STAGES] = !v_q[STAGES] || i_ready;
        for (int k = STAGES - 1; k >= 1; k--) begin
            ld[k] = !v_q[k] || ld[k+1];
        end
        v_in[1] = i_valid;
        for (int k = 2; k <= STAGES; k++) begin
            v_in[k] = v_q[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v_q <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_in[k];
                end
            end
        end
    end

    assign o_ready = ld[1];
    assign o_valid = v_q[STAGES];

    for (genvar k = 1; k <= STAGES; k++) begin : g_stg
        localparam int LO = (k - 1) * SEG;

        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_nx;
        logic             c_in;
        logic             c_nx;
        logic             en;
        logic [GPS-1:0]   grp_g;
        logic [GPS-1:0]   grp_p;
        logic [GPS-1:0]   grp_c;
        logic [GPS-1:0]   grp_co;
        logic [SEG-1:0]   seg_s;

        if (k == 1) begin : g_src
            assign a_in = i_a;
            assign b_in = i_b ^ {WIDTH{i_sub}};
            assign s_in = '0;
            assign c_in = i_cin;
        end else begin : g_src
            assign a_in = g_stg[k-1].g_reg.a_q;
            assign b_in = g_stg[k-1].g_reg.b_q;
            assign s_in = g_stg[k-1].g_reg.s_q;
            assign c_in = g_stg[k-1].g_reg.c_q;
        end

        // Data registers only move with a real entry; bubbles leave them.
        assign en = ld[k] && v_in[k];

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla_block #(
                .BLOCK(BLOCK)
            ) u_blk (
                .a   (a_in[LO + j*BLOCK +: BLOCK]),
                .b   (b_in[LO + j*BLOCK +: BLOCK]),
                .cin (grp_c[j]),
                .sum (seg_s[j*BLOCK +: BLOCK]),
                .g   (grp_g[j]),
                .p   (grp_p[j]),
                .cout(grp_co[j])
            );
        end

        always_comb begin : lookahead
            logic ga;
            logic pa;
            grp_c = '0;
            ga    = 1'b0;
            pa    = 1'b1;
            for (int j = 0; j < GPS; j++) begin
                ga = 1'b0;
                pa = 1'b1;
                for (int m = j - 1; m >= 0; m--) begin
                    ga = ga | (pa & grp_g[m]);
                    pa = pa & grp_p[m];
                end
                grp_c[j] = ga | (pa & c_in);
            end
        end

        always_comb begin
            s_nx            = s_in;
            s_nx[LO +: SEG] = seg_s;
        end

        assign c_nx = grp_co[GPS-1];

        if (k < STAGES) begin : g_reg
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (en) begin
                    a_q <= a_in;
                    b_q <= b_in;
                    s_q <= s_nx;
                    c_q <= c_nx;
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] s_q;
            flags_t           flg_q;
            logic             msb_cin;

            // Carry into the MSB recovered from its sum bit.
            assign msb_cin = s_nx[WIDTH-1] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1];

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    s_q   <= '0;
                    flg_q <= '0;
                end else if (en) begin
                    s_q        <= s_nx;
                    flg_q.c    <= c_nx;
                    flg_q.ovf  <= c_nx ^ msb_cin;
                    flg_q.zero <= (s_nx == '0);
                end
            end

            assign o_s    = s_q;
            assign o_c    = flg_q.c;
            assign o_ovf  = flg_q.ovf;
            assign o_zero = flg_q.zero;
        end
    end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor built from BLOCK-bit CLA groups.
- The WIDTH-bit operation is split into STAGES segments. The carry crosses segment boundaries through registers, so the block reaches wide widths at high clock rate.
- Upstream and downstream use valid/ready handshakes. The result carries carry-out, signed-overflow and zero flags.
- The block sits in the datapath library as the general-purpose add/sub unit for ALU and accumulator blocks.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK*STAGES.
- BLOCK, 4, bits per CLA group (g/p look-ahead within the group).
- STAGES, 2, pipeline segments; latency in cycles; range 1..WIDTH/BLOCK.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- i_valid  in  1  upstream operands valid.
- o_ready  out  1  block can accept; a transfer occurs when i_valid and o_ready are both high at a rising edge.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_cin  in  1  carry-in; in sub mode this is not-borrow-in.
- i_sub  in  1  0: A+B+cin; 1: A+~B+cin.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts; a transfer occurs when o_valid and i_ready are both high at a rising edge.
- o_s  out  WIDTH  sum/difference.
- o_c  out  1  carry-out of the MSB; in sub mode 1 means no borrow.
- o_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- o_zero  out  1  o_s == 0.

Behaviour:
- Datapath:
  - The effective B is i_b XOR {WIDTH{i_sub}}.
  - Segment k covers bits [(k+1)*SEG-1 : k*SEG], where SEG = WIDTH/STAGES.
  - Inside a segment, BLOCK-bit groups use full look-ahead. Group g/p signals feed a second-level look-ahead across the groups; there is no ripple between groups.
- Pipeline:
  - Stage k computes segment k from the registered carry of stage k-1, or from i_cin for k=0.
  - Not-yet-processed upper operand bits and already-computed lower sum bits are carried forward in the stage registers (skew/deskew).
  - Output registers are the stage-STAGES registers.
- Latency and throughput:
  - Operands accepted at edge t appear on outputs with o_valid=1 from edge t+STAGES-1 onward.
  - STAGES=1 gives a single registered stage.
  - Throughput is one operation per cycle when i_ready=1.
- Handshake:
  - Each stage has a valid bit v[k].
  - Stage k loads when !v[k] || advance[k+1]; the last stage advances on i_ready.
  - o_ready = !v[1] || stage 1 loads from its successor, combinational from i_ready.
  - o_valid = v[STAGES].
  - Outputs hold stable while o_valid && !i_ready.
  - Inputs are ignored when no transfer occurs.
- Bubbles: an empty stage accepts a new entry even while downstream stalls, so bubbles compress.
- Flags: o_c, o_ovf and o_zero are registered with o_s in the final stage and are valid only while o_valid=1.
- Reset, sampled at a rising edge with i_rst_n=0:
  - All v[k] clear.
  - o_valid=0; o_s=0; o_c=0; o_ovf=0; o_zero=0.
  - o_ready=1 from the first cycle after reset.
  - In-flight operations are discarded; nothing is emitted for them after reset.
- Boundaries:
  - Simultaneous accept and emit with all stages full is allowed; the pipeline stays full and no data is lost.
  - i_ready=0 with all stages full drives o_ready=0.
  - Wrap-around: results are taken modulo 2^WIDTH and the carry is reported on o_c.

Decomposition:
- Shared header/package holds:
  - the legality check WIDTH % (BLOCK*STAGES) == 0 (elaboration error if violated);
  - the derived constants SEG and GROUPS_PER_SEG.
- Sub-module cla_block (BLOCK-bit group):
  - inputs: a, b, cin;
  - outputs: sum, group generate G, group propagate P, cout.
- The top level instantiates GROUPS_PER_SEG cla_block instances per segment, a look-ahead across groups, and the stage registers and handshake logic.

Test Plan (WIDTH=16, BLOCK=4, STAGES=2 unless noted):
- Carry wrap: A=0xFFFF, B=0x0001, cin=0, add -> after 2 cycles o_s=0x0000, o_c=1, o_zero=1, o_ovf=0.
- Signed overflow: A=0x7FFF, B=0x0001, add -> o_s=0x8000, o_c=0, o_ovf=1. Subtract A=0x8000, B=0x0001, cin=1 -> o_s=0x7FFF, o_c=1, o_ovf=1.
- Segment-crossing carry: A=0x00FF, B=0x0001, add -> o_s=0x0100, o_c=0. Repeat with STAGES=1 and STAGES=4 -> same results, latency 1 and 4 respectively.
- Back-pressure: stream 5 ops back-to-back and hold i_ready=0 for 3 cycles mid-stream -> o_ready falls once 2 ops are held; outputs stay stable; all 5 results emerge in order with none lost or duplicated.
- Reset mid-operation: 2 ops in flight, assert i_rst_n=0 for 1 edge -> o_valid=0 and all outputs 0 next cycle; o_ready=1; no stale result appears afterwards.
- Random: 10k random A, B, cin, sub with random i_ready -> every emitted {o_c, o_s} equals A + (sub ? ~B : B) + cin mod 2^17, in order; flags match the reference model.
